// File: rtl/wb_pkg.sv
// Shared types for the write-back commit stage: register-file write request and helpers.
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] waddr;
    logic [XLEN-1:0]       wdata;
  } wb_req_t;

  // Writes to x0 never reach the register file.
  function automatic logic wb_is_write(input wb_req_t req);
    return req.we && (req.waddr != '0);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back requests; extra pointer bit distinguishes full from empty.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  wb_req_t push_data,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output wb_req_t head
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                 (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);

  // A simultaneous pop makes room, so a push into a full FIFO is legal then.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head = mem[rd_ptr[IDX_W-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and an unreset array maps onto plain RAM/flops cheaply.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[IDX_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/wb_commit.sv
// Write-back commit: pipeline/long-latency arbitration onto one register-file port.
// Optional pending-register scoreboard built when WB_SCOREBOARD_EN is defined.
module wb_commit
  import wb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_valid,
  input  logic                  pipe_we,
  input  logic [REG_ADDR_W-1:0] pipe_waddr,
  input  logic [XLEN-1:0]       pipe_wdata,
  input  logic                  lu_valid,
  output logic                  lu_ready,
  input  logic [REG_ADDR_W-1:0] lu_waddr,
  input  logic [XLEN-1:0]       lu_wdata,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_waddr,
  input  logic [REG_ADDR_W-1:0] q_raddr1,
  input  logic [REG_ADDR_W-1:0] q_raddr2,
  output logic                  busy1,
  output logic                  busy2,
  output logic                  wb_stall,
  output logic                  we,
  output logic [REG_ADDR_W-1:0] waddr,
  output logic [XLEN-1:0]       wdata
);

  localparam int                CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  wb_req_t          pipe_req;
  wb_req_t          lu_req;
  wb_req_t          fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             lu_push;
  logic             fifo_pop;
  logic             pipe_wins;
  logic             lu_commit;
  logic [CNT_W-1:0] starve_cnt;

  assign pipe_req = '{we: pipe_we, waddr: pipe_waddr, wdata: pipe_wdata};
  assign lu_req   = '{we: 1'b1, waddr: lu_waddr, wdata: lu_wdata};

  // lu_ready comes from registered pointers only, so a pop frees it next cycle.
  assign lu_ready  = !fifo_full;
  assign lu_push   = lu_valid && lu_ready;
  assign pipe_wins = pipe_valid && wb_is_write(pipe_req);
  assign fifo_pop  = !pipe_wins && !fifo_empty;
  assign lu_commit = fifo_pop && wb_is_write(fifo_head);

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (lu_push),
    .push_data(lu_req),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  // Address/data hold on idle cycles; only the enable drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      we <= pipe_wins || lu_commit;
      if (pipe_wins) begin
        waddr <= pipe_req.waddr;
        wdata <= pipe_req.wdata;
      end else if (lu_commit) begin
        waddr <= fifo_head.waddr;
        wdata <= fifo_head.wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (fifo_pop || fifo_empty) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign wb_stall = (starve_cnt == LIMIT);

`ifdef WB_SCOREBOARD_EN
  logic [31:0] pending;
  logic [31:0] pending_next;

  // Clear first, then set, so a same-cycle issue to the committing register wins.
  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    pending_next = pending;
    if (lu_commit) pending_next[fifo_head.waddr] = 1'b0;
    if (iss_valid) pending_next[iss_waddr] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pending_next;
  end

  assign busy1 = pending[q_raddr1];
  assign busy2 = pending[q_raddr2];
`else
  logic unused_sb;
  assign unused_sb = &{1'b0, iss_valid, iss_waddr, q_raddr1, q_raddr2};
  assign busy1     = 1'b0;
  assign busy2     = 1'b0;
`endif

endmodule

// File: tb/tb_wb_commit.sv
// Directed self-checking bench for wb_commit (DEPTH=2, STARVE_LIMIT=4).
module tb_wb_commit;
  import wb_pkg::*;

`ifdef WB_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  pipe_valid, pipe_we;
  logic [REG_ADDR_W-1:0] pipe_waddr;
  logic [XLEN-1:0]       pipe_wdata;
  logic                  lu_valid, lu_ready;
  logic [REG_ADDR_W-1:0] lu_waddr;
  logic [XLEN-1:0]       lu_wdata;
  logic                  iss_valid;
  logic [REG_ADDR_W-1:0] iss_waddr, q_raddr1, q_raddr2;
  logic                  busy1, busy2, wb_stall, we;
  logic [REG_ADDR_W-1:0] waddr;
  logic [XLEN-1:0]       wdata;

  int checks = 0;
  int errors = 0;

  wb_commit #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .pipe_valid(pipe_valid),
    .pipe_we   (pipe_we),
    .pipe_waddr(pipe_waddr),
    .pipe_wdata(pipe_wdata),
    .lu_valid  (lu_valid),
    .lu_ready  (lu_ready),
    .lu_waddr  (lu_waddr),
    .lu_wdata  (lu_wdata),
    .iss_valid (iss_valid),
    .iss_waddr (iss_waddr),
    .q_raddr1  (q_raddr1),
    .q_raddr2  (q_raddr2),
    .busy1     (busy1),
    .busy2     (busy2),
    .wb_stall  (wb_stall),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; samples taken afterwards are 1ns past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe(input logic v, input logic [4:0] a, input logic [31:0] d);
    pipe_valid = v;
    pipe_we    = v;
    pipe_waddr = a;
    pipe_wdata = d;
  endtask

  task automatic lu(input logic v, input logic [4:0] a, input logic [31:0] d);
    lu_valid = v;
    lu_waddr = a;
    lu_wdata = d;
  endtask

  task automatic port(input string tag, input logic e, input logic [4:0] a, input logic [31:0] d);
    check({tag, ".we"}, 32'(we), 32'(e));
    check({tag, ".waddr"}, 32'(waddr), 32'(a));
    check({tag, ".wdata"}, wdata, d);
  endtask

  initial begin
    rst = 1'b1;
    pipe(1'b0, 5'd0, 32'h0);
    lu(1'b0, 5'd0, 32'h0);
    iss_valid = 1'b0;
    iss_waddr = '0;
    q_raddr1  = 5'd9;
    q_raddr2  = 5'd0;
    step();
    step();
    port("reset", 1'b0, 5'd0, 32'h0);
    check("reset.lu_ready", 32'(lu_ready), 32'd1);
    check("reset.wb_stall", 32'(wb_stall), 32'd0);
    check("reset.busy1", 32'(busy1), 32'd0);
    rst = 1'b0;
    step();

    // Pipeline only, then writes that must not use the port.
    pipe(1'b1, 5'd5, 32'hDEADBEEF);
    step();
    port("pipe_x5", 1'b1, 5'd5, 32'hDEADBEEF);
    pipe(1'b1, 5'd0, 32'h123);
    step();
    port("pipe_x0", 1'b0, 5'd5, 32'hDEADBEEF);
    pipe(1'b1, 5'd6, 32'h456);
    pipe_we = 1'b0;
    step();
    port("pipe_nowe", 1'b0, 5'd5, 32'hDEADBEEF);

    // Conflict: pipeline first, queued long-latency result next.
    pipe(1'b1, 5'd3, 32'h11);
    lu(1'b1, 5'd7, 32'h22);
    step();
    pipe(1'b0, 5'd0, 32'h0);
    lu(1'b0, 5'd0, 32'h0);
    port("conf_x3", 1'b1, 5'd3, 32'h11);
    step();
    port("conf_x7", 1'b1, 5'd7, 32'h22);
    step();
    port("conf_idle", 1'b0, 5'd7, 32'h22);

    // Long-latency x0 result is accepted and silently discarded.
    lu(1'b1, 5'd0, 32'h55);
    step();
    lu(1'b0, 5'd0, 32'h0);
    step();
    port("lu_x0_pop", 1'b0, 5'd7, 32'h22);
    step();
    port("lu_x0_after", 1'b0, 5'd7, 32'h22);

    // Fill and starve: pipeline writes every cycle.
    pipe(1'b1, 5'd1, 32'h1000);
    lu(1'b1, 5'd10, 32'hA0);
    step();
    check("fill1.lu_ready", 32'(lu_ready), 32'd1);
    check("fill1.stall", 32'(wb_stall), 32'd0);
    pipe(1'b1, 5'd1, 32'h1001);
    lu(1'b1, 5'd11, 32'hB0);
    step();
    check("fill2.lu_ready", 32'(lu_ready), 32'd0);
    pipe(1'b1, 5'd1, 32'h1002);
    lu(1'b0, 5'd0, 32'h0);
    step();
    check("starve2.stall", 32'(wb_stall), 32'd0);
    pipe(1'b1, 5'd1, 32'h1003);
    step();
    check("starve3.stall", 32'(wb_stall), 32'd0);
    port("starve3.port", 1'b1, 5'd1, 32'h1003);
    pipe(1'b1, 5'd1, 32'h1004);
    lu(1'b1, 5'd12, 32'hC0);
    step();
    check("starve4.stall", 32'(wb_stall), 32'd1);
    check("starve4.lu_ready", 32'(lu_ready), 32'd0);
    pipe(1'b0, 5'd0, 32'h0);
    lu(1'b0, 5'd0, 32'h0);
    step();
    port("bubble1", 1'b1, 5'd10, 32'hA0);
    check("bubble1.stall", 32'(wb_stall), 32'd0);
    check("bubble1.lu_ready", 32'(lu_ready), 32'd1);
    step();
    port("drain2", 1'b1, 5'd11, 32'hB0);
    step();
    port("drained", 1'b0, 5'd11, 32'hB0);

    // Scoreboard set/clear and same-cycle set-wins.
    iss_valid = 1'b1;
    iss_waddr = 5'd9;
    step();
    iss_valid = 1'b1;
    iss_waddr = 5'd0;
    check("sb_issue.busy1", 32'(busy1), 32'(SB));
    check("sb_issue.busy2", 32'(busy2), 32'd0);
    lu(1'b1, 5'd9, 32'h99);
    step();
    iss_valid = 1'b0;
    lu(1'b0, 5'd0, 32'h0);
    check("sb_queued.busy1", 32'(busy1), 32'(SB));
    check("sb_x0.busy2", 32'(busy2), 32'd0);
    step();
    port("sb_commit", 1'b1, 5'd9, 32'h99);
    check("sb_commit.busy1", 32'(busy1), 32'd0);
    iss_valid = 1'b1;
    iss_waddr = 5'd9;
    step();
    iss_valid = 1'b0;
    lu(1'b1, 5'd9, 32'h98);
    step();
    lu(1'b0, 5'd0, 32'h0);
    iss_valid = 1'b1;
    iss_waddr = 5'd9;
    step();
    iss_valid = 1'b0;
    port("sb_setwins", 1'b1, 5'd9, 32'h98);
    check("sb_setwins.busy1", 32'(busy1), 32'(SB));

    // Reset mid-drain with two entries queued and x9 still pending.
    pipe(1'b1, 5'd2, 32'h200);
    lu(1'b1, 5'd20, 32'h2000);
    step();
    lu(1'b1, 5'd21, 32'h2100);
    step();
    pipe(1'b0, 5'd0, 32'h0);
    lu(1'b0, 5'd0, 32'h0);
    check("pre_rst.we", 32'(we), 32'd1);
    check("pre_rst.lu_ready", 32'(lu_ready), 32'd0);
    rst = 1'b1;
    #1;
    port("rst_async", 1'b0, 5'd0, 32'h0);
    check("rst_async.lu_ready", 32'(lu_ready), 32'd1);
    check("rst_async.busy1", 32'(busy1), 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      port($sformatf("post_rst%0d", i), 1'b0, 5'd0, 32'h0);
    end
    check("post_rst.stall", 32'(wb_stall), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_commit.md
# wb_commit

Write-back commit stage driving the single register-file write port (`we`/`waddr`/`wdata`). It merges two result sources: the in-order pipeline (fixed priority, never back-pressured) and a long-latency unit (mul/div) buffered in a small FIFO with valid/ready. It also keeps a scoreboard of destination registers with long-latency results still in flight, so issue logic can stall on them.

## Interface
- `DEPTH`, 2, long-latency result FIFO entries; power of two, ≥2
- `STARVE_LIMIT`, 4, consecutive blocked-drain cycles before `wb_stall` asserts; ≥1
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `pipe_valid`  in  1  pipeline result present this cycle
- `pipe_we`  in  1  pipeline result writes a register
- `pipe_waddr`  in  5  pipeline destination
- `pipe_wdata`  in  32  pipeline result
- `lu_valid`  in  1  long-latency result offered
- `lu_ready`  out  1  FIFO can accept (`!full`)
- `lu_waddr`  in  5  long-latency destination
- `lu_wdata`  in  32  long-latency result
- `iss_valid`  in  1  long-latency op issued this cycle
- `iss_waddr`  in  5  its destination, marked pending
- `q_raddr1`, `q_raddr2`  in  5 each  scoreboard query addresses
- `busy1`, `busy2`  out  1 each  queried register pending
- `wb_stall`  out  1  upstream must insert a bubble next cycle
- `we`  out  1  register-file write enable
- `waddr`  out  5  register-file write address
- `wdata`  out  32  register-file write data

## Operation
- Pipeline wants the port when `pipe_valid && pipe_we && pipe_waddr != 0`. A pipeline write with address 0 is dropped and does not occupy the port.
- The long-latency push is `lu_valid && lu_ready`; an entry with address 0 is accepted and then discarded when it reaches the head, with no port use.
- Each cycle the port winner is the pipeline if it wants the port. Otherwise the FIFO head, if the FIFO is non-empty, pops. Otherwise the port is idle.
- The FIFO supports push and pop in the same cycle, including when full: a pop frees `lu_ready` only in the next cycle, because `lu_ready` depends on the registered count only.
- Starvation counter:
  - Increments when the FIFO is non-empty and the pipeline wins.
  - Clears when the FIFO pops or is empty.
  - It saturates at `STARVE_LIMIT`.
  - `wb_stall` = (counter == `STARVE_LIMIT`).
  - Upstream must deliver `pipe_valid=0` in the cycle after `wb_stall` is sampled high; that bubble drains one entry and clears the counter.
- Scoreboard (32 pending bits, bit 0 always 0):
  - `iss_valid` sets `pending[iss_waddr]`.
  - A FIFO commit clears `pending[head.waddr]`.
  - If a set and a clear hit the same register in the same cycle, the set wins.
  - `busyN` = `pending[q_raddrN]`, combinational.
- Ordering contract: issue logic must not issue to, or let the pipeline write, any register that is busy. `wb_commit` does not check this.

## Timing
- Outputs `we`/`waddr`/`wdata` are registered. A winner selected in cycle N appears at the port in cycle N+1, and the register file captures it at the end of N+1.
- Latency: pipeline result to port is 1 cycle. A long-latency result pushed into an empty FIFO with an idle pipeline reaches the port in 2 cycles (push edge, then pop edge).
- Reset values (asynchronous, immediate): `we`=0, `waddr`=0, `wdata`=0, FIFO empty, `lu_ready`=1, starvation counter 0, `wb_stall`=0, all pending bits 0, `busy1`/`busy2`=0.
- Reset asserted mid-operation discards FIFO contents and pending bits; no partial write is emitted.
- On an idle cycle, `we`=0 and `waddr`/`wdata` hold their previous values.

## Configuration
- `WB_SCOREBOARD_EN` defined: the pending bit array is built as described above.
- Undefined: no pending storage; `busy1`/`busy2` are tied to 0 and `iss_*`/`q_*` are ignored. The commit and FIFO behaviour is unchanged.

## Structure
- Package `wb_pkg` holds:
  - `REG_ADDR_W`=5 and `XLEN`=32.
  - Typedef `wb_req_t` {we, waddr, wdata}.
  - Function `wb_is_write(wb_req_t)`, which returns we && waddr != 0.
- Sub-module `wb_fifo`: a parameterised synchronous FIFO of `wb_req_t`.
  - Ports: `clk`/`rst`, push/pop, full/empty, head.
  - Pointer width is log2(DEPTH)+1, with wrap-around compare.
- The top level holds arbitration, the starvation counter, the scoreboard and the output registers.

## Test plan
- Reset check: hold `rst`=1 → `we`=0, `lu_ready`=1, `wb_stall`=0, `busy1`=0.
- Pipeline only: write x5=0xDEADBEEF in cycle N → `we`=1, `waddr`=5, `wdata`=0xDEADBEEF in N+1. Write to x0 → `we` stays 0.
- Conflict: pipeline x3=0x11 and push of long-latency x7=0x22 in the same cycle, pipeline idle afterwards → port shows x3 then x7 on consecutive cycles.
- Full/starve with `DEPTH`=2, `STARVE_LIMIT`=4:
  - Fill 2 entries while the pipeline writes every cycle → `lu_ready`=0.
  - `wb_stall` rises after 4 blocked cycles.
  - One bubble → one entry drains, `wb_stall`=0 and `lu_ready`=1 the next cycle.
- Scoreboard: `iss_valid`, x9 → `busy1`=1 for `q_raddr1`=9. Commit x9 → busy clears the cycle after the pop. Issue x9 in the same cycle as the x9 commit → busy stays 1.
- Reset mid-drain: assert `rst` with 2 entries queued → `we`=0 immediately, and no stale write after deassertion.
